cipher_block_packer: RTL and testbench

CIPHER_BLOCK_PACKER -- requirements
Module: cipher_block_packer

---
 rtl/cipher_block_packer_pkg.sv | 23 ++
 rtl/cipher_block_packer_lanes.sv | 51 +++++
 rtl/cipher_block_packer.sv | 149 ++++++++++++++
 tb/tb_cipher_block_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_block_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cipher_block_packer_pkg
// Description : Shared ChaCha20-Poly1305 types and constants for the packer.
// Revision    : 1.0 - initial release
// ============================================================================
package cipher_block_packer_pkg;

    typedef logic [7:0] word_t;

    localparam int c_BLK_BYTES    = 16;
    localparam int c_KS_BLK_BYTES = 64;
    localparam int c_IDX_W        = $clog2(c_BLK_BYTES);
    localparam int c_KS_CNT_W     = $clog2(c_KS_BLK_BYTES);
    localparam int c_BLK_W        = 8 * c_BLK_BYTES;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cipher_block_packer_lanes.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_packer
// Description : Writes bytes into successive lanes of a 16-byte pack register.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_packer
    import cipher_block_packer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [7:0]           wr_byte,
    input  logic                 clr,
    output logic [c_BLK_W-1:0]   pack,
    output logic [c_IDX_W-1:0]   idx
);

    logic [c_BLK_W-1:0] r_pack_q;
    logic [c_BLK_W-1:0] w_pack_d;
    logic [c_IDX_W-1:0] r_idx_q;
    logic [c_IDX_W-1:0] w_idx_d;

    // clr and wr_en never coincide: writes happen in FILL, clears in EMIT
    always_comb begin
        w_pack_d = r_pack_q;
        w_idx_d  = r_idx_q;
        if (clr) begin
            w_pack_d = '0;
            w_idx_d  = '0;
        end else if (wr_en) begin
            w_pack_d[{r_idx_q, 3'b000} +: 8] = wr_byte;
            w_idx_d                          = r_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack_q <= '0;
            r_idx_q  <= '0;
        end else begin
            r_pack_q <= w_pack_d;
            r_idx_q  <= w_idx_d;
        end
    end

    assign pack = r_pack_q;
    assign idx  = r_idx_q;

endmodule
`default_nettype wire

// File: rtl/cipher_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : cipher_block_packer
// Description : XORs keystream with plaintext and packs ciphertext into
//               16-byte blocks, tracking keystream blocks and message length.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_block_packer
    import cipher_block_packer_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         ks_byte,
    input  logic               ks_valid,
    output logic               ks_ready,
    input  logic [7:0]         pt_byte,
    input  logic               pt_valid,
    input  logic               pt_last,
    output logic               pt_ready,
    output logic [7:0]         ct_byte,
    output logic               ct_valid,
    output logic               ks_blk_done,
    output logic [127:0]       blk_data,
    output logic [4:0]         blk_bytes,
    output logic               blk_last,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [LEN_W-1:0]   msg_len
);

    state_e                 r_state_q;
    state_e                 w_state_d;
    logic [7:0]             r_ct_byte_q;
    logic [7:0]             w_ct_byte_d;
    logic                   r_ct_valid_q;
    logic                   w_ct_valid_d;
    logic                   r_ks_done_q;
    logic                   w_ks_done_d;
    logic [c_KS_CNT_W-1:0]  r_ks_cnt_q;
    logic [c_KS_CNT_W-1:0]  w_ks_cnt_d;
    logic [4:0]             r_blk_bytes_q;
    logic [4:0]             w_blk_bytes_d;
    logic                   r_blk_last_q;
    logic                   w_blk_last_d;
    logic [LEN_W-1:0]       r_run_len_q;
    logic [LEN_W-1:0]       w_run_len_d;
    logic [LEN_W-1:0]       r_msg_len_q;
    logic [LEN_W-1:0]       w_msg_len_d;

    logic                   w_xfer;
    logic                   w_accept;
    logic [7:0]             w_ct;
    logic [c_IDX_W-1:0]     w_idx;
    logic [c_BLK_W-1:0]     w_pack;

    // Reset gates the handshakes so nothing is consumed during a reset cycle
    assign w_xfer   = !rst && (r_state_q == FILL) && ks_valid && pt_valid;
    assign w_accept = !rst && (r_state_q == EMIT) && blk_ready;
    assign w_ct     = ks_byte ^ pt_byte;

    byte_lane_packer u_lanes (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_xfer),
        .wr_byte (w_ct),
        .clr     (w_accept),
        .pack    (w_pack),
        .idx     (w_idx)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_ct_byte_d   = r_ct_byte_q;
        w_ct_valid_d  = w_xfer;
        w_ks_done_d   = w_xfer && (pt_last || (&r_ks_cnt_q));
        w_ks_cnt_d    = r_ks_cnt_q;
        w_blk_bytes_d = r_blk_bytes_q;
        w_blk_last_d  = r_blk_last_q;
        w_run_len_d   = r_run_len_q;
        w_msg_len_d   = r_msg_len_q;

        case (r_state_q)
            FILL: begin
                if (w_xfer) begin
                    w_ct_byte_d   = w_ct;
                    // A message end abandons the rest of the keystream block
                    w_ks_cnt_d    = pt_last ? '0 : r_ks_cnt_q + 1'b1;
                    w_blk_bytes_d = {1'b0, w_idx} + 5'd1;
                    w_blk_last_d  = pt_last;
                    w_run_len_d   = r_run_len_q + 1'b1;
                    if (pt_last || (&w_idx)) begin
                        w_state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (w_accept) begin
                    w_state_d     = FILL;
                    w_blk_bytes_d = '0;
                    w_blk_last_d  = 1'b0;
                    if (r_blk_last_q) begin
                        w_msg_len_d = r_run_len_q;
                        w_run_len_d = '0;
                    end
                end
            end
            default: w_state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= FILL;
            r_ct_byte_q   <= '0;
            r_ct_valid_q  <= 1'b0;
            r_ks_done_q   <= 1'b0;
            r_ks_cnt_q    <= '0;
            r_blk_bytes_q <= '0;
            r_blk_last_q  <= 1'b0;
            r_run_len_q   <= '0;
            r_msg_len_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_ct_byte_q   <= w_ct_byte_d;
            r_ct_valid_q  <= w_ct_valid_d;
            r_ks_done_q   <= w_ks_done_d;
            r_ks_cnt_q    <= w_ks_cnt_d;
            r_blk_bytes_q <= w_blk_bytes_d;
            r_blk_last_q  <= w_blk_last_d;
            r_run_len_q   <= w_run_len_d;
            r_msg_len_q   <= w_msg_len_d;
        end
    end

    assign ks_ready    = w_xfer;
    assign pt_ready    = w_xfer;
    assign ct_byte     = r_ct_byte_q;
    assign ct_valid    = r_ct_valid_q;
    assign ks_blk_done = r_ks_done_q;
    assign blk_data    = w_pack;
    assign blk_bytes   = r_blk_bytes_q;
    assign blk_last    = r_blk_last_q;
    assign blk_valid   = (r_state_q == EMIT);
    assign msg_len     = r_msg_len_q;

endmodule
`default_nettype wire

// File: tb/tb_cipher_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cipher_block_packer
// Description : Scoreboard bench for cipher_block_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cipher_block_packer;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    ks_byte, pt_byte;
    logic          ks_valid, ks_ready, pt_valid, pt_last, pt_ready;
    logic [7:0]    ct_byte;
    logic          ct_valid, ks_blk_done;
    logic [127:0]  blk_data;
    logic [4:0]    blk_bytes;
    logic          blk_last, blk_valid, blk_ready;
    logic [31:0]   msg_len;

    always #5 clk = ~clk;

    cipher_block_packer #(.LEN_W(32)) dut (
        .clk(clk), .rst(rst),
        .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .pt_byte(pt_byte), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
        .ct_byte(ct_byte), .ct_valid(ct_valid), .ks_blk_done(ks_blk_done),
        .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_last(blk_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .msg_len(msg_len)
    );

    typedef struct packed {
        logic [127:0] data;
        logic [4:0]   bytes;
        logic         last;
        logic [31:0]  len;
    } blk_t;

    logic [7:0]   ct_q[$];
    logic         kd_q[$];
    blk_t         blk_q[$];

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] m_pack = '0;
    int           m_idx = 0;
    int           m_ks = 0;
    logic [31:0]  m_run = '0;
    int           kd_pulses = 0;
    int           blk_count = 0;
    bit           pend_len = 0;
    logic [31:0]  exp_len = '0;
    bit           toggle_mode = 0;
    int           cyc = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drv_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic model_xfer(input logic [7:0] p, input logic [7:0] k, input logic l);
        logic [7:0] c;
        c = p ^ k;
        ct_q.push_back(c);
        kd_q.push_back(l || (m_ks == 63));
        m_ks = (l || (m_ks == 63)) ? 0 : m_ks + 1;
        m_pack[8*m_idx +: 8] = c;
        m_idx++;
        m_run++;
        if (m_idx == 16 || l) begin
            blk_q.push_back('{data: m_pack, bytes: 5'(m_idx), last: l, len: m_run});
            m_pack = '0;
            m_idx  = 0;
            if (l) m_run = '0;
        end
    endtask

    task automatic send_byte(input logic [7:0] p, input logic [7:0] k, input logic l);
        int  t;
        bit  done;
        t    = 0;
        done = 0;
        while (!done) begin
            drv_edge();
            ks_byte  = k;
            pt_byte  = p;
            pt_last  = l;
            ks_valid = 1'b1;
            pt_valid = toggle_mode ? cyc[0] : 1'b1;
            cyc++;
            #1;
            if (!pt_valid) chk("rdy_gap", {pt_ready, ks_ready}, 2'b00);
            else if (pt_ready) begin
                model_xfer(p, k, l);
                done = 1;
            end
            t++;
            if (!done && t > 300) begin
                chk("xfer_timeout", 1, 0);
                done = 1;
            end
        end
    endtask

    task automatic idle();
        drv_edge();
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        pt_last  = 1'b0;
    endtask

    task automatic send_msg(input int n, input bit ramp, input bit last);
        for (int i = 0; i < n; i++) begin
            if (ramp) send_byte(8'(i), 8'hFF, last && (i == n - 1));
            else      send_byte(8'($urandom), 8'($urandom), last && (i == n - 1));
        end
        idle();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((ct_q.size() != 0 || blk_q.size() != 0 || pend_len) && t < 500) begin
            drv_edge();
            t++;
        end
        if (t >= 500) chk("drain_timeout", 1, 0);
        repeat (2) drv_edge();
    endtask

    // Sample after all stimulus of the cycle has settled
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (pend_len) begin
                chk("msg_len", msg_len, exp_len);
                pend_len = 0;
            end
            if (ct_valid) begin
                if (ct_q.size() == 0) chk("ct_spurious", 1, 0);
                else begin
                    chk("ct_byte", ct_byte, ct_q.pop_front());
                    chk("ks_blk_done", ks_blk_done, kd_q.pop_front());
                end
            end else if (ks_blk_done) chk("ks_blk_done_stray", 1, 0);
            if (ks_blk_done) kd_pulses++;
            if (blk_valid) begin
                chk("rdy_emit", {pt_ready, ks_ready}, 2'b00);
                if (blk_q.size() == 0) chk("blk_spurious", 1, 0);
                else begin
                    chk("blk_data", blk_data, blk_q[0].data);
                    chk("blk_bytes", blk_bytes, blk_q[0].bytes);
                    chk("blk_last", blk_last, blk_q[0].last);
                    if (blk_ready) begin
                        if (blk_q[0].last) begin
                            pend_len = 1;
                            exp_len  = blk_q[0].len;
                        end
                        void'(blk_q.pop_front());
                        blk_count++;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ct_valid"}, ct_valid, 0);
        chk({tag, "_ct_byte"}, ct_byte, 0);
        chk({tag, "_kd"}, ks_blk_done, 0);
        chk({tag, "_blk_valid"}, blk_valid, 0);
        chk({tag, "_blk_data"}, blk_data, 0);
        chk({tag, "_blk_bytes"}, blk_bytes, 0);
        chk({tag, "_blk_last"}, blk_last, 0);
        chk({tag, "_msg_len"}, msg_len, 0);
    endtask

    initial begin
        rst = 1'b1; ks_byte = '0; pt_byte = '0; ks_valid = 0; pt_valid = 0;
        pt_last = 0; blk_ready = 1'b1;
        repeat (3) drv_edge();
        check_reset_outputs("rst0");
        rst = 1'b0;

        // 16-byte ramp against all-ones keystream
        kd_pulses = 0;
        send_msg(16, 1, 1);
        drain();
        chk("t1_kd_count", kd_pulses, 1);

        // 5-byte message
        kd_pulses = 0;
        send_msg(5, 0, 1);
        drain();
        chk("t2_kd_count", kd_pulses, 1);

        // 130-byte message spanning three keystream blocks
        kd_pulses = 0;
        blk_count = 0;
        send_msg(130, 0, 1);
        drain();
        chk("t3_kd_count", kd_pulses, 3);
        chk("t3_blk_count", blk_count, 9);

        // downstream backpressure during EMIT
        blk_ready = 1'b0;
        fork
            send_msg(20, 0, 1);
            begin
                int t;
                t = 0;
                while (!blk_valid && t < 400) begin
                    drv_edge();
                    t++;
                end
                if (t >= 400) chk("t4_emit_timeout", 1, 0);
                repeat (10) drv_edge();
                blk_ready = 1'b1;
            end
        join
        drain();

        // plaintext valid toggling
        toggle_mode = 1;
        send_msg(24, 0, 1);
        toggle_mode = 0;
        drain();

        // reset mid-message drops the partial block
        send_msg(7, 0, 0);
        repeat (2) drv_edge();
        rst = 1'b1;
        ks_valid = 1'b1;
        pt_valid = 1'b1;
        #1;
        chk("rst_ready", {pt_ready, ks_ready}, 2'b00);
        drv_edge();
        check_reset_outputs("rst1");
        m_pack = '0; m_idx = 0; m_ks = 0; m_run = '0;
        ct_q.delete(); kd_q.delete(); blk_q.delete(); pend_len = 0;
        rst = 1'b0;
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        blk_count = 0;
        send_msg(3, 0, 1);
        drain();
        chk("t6_blk_count", blk_count, 1);
        chk("t6_msg_len", msg_len, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
